// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory port between instruction fetch and data access.
// Data wins by default; a waiting fetch is forced through after MAX_DATA_BURST data grants.
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | no transaction outstanding, arbitrate on this edge
// DATA    | data request granted, waiting for mem_ack
// INSTR   | fetch request granted, waiting for mem_ack
module mem_port_arbiter #(
    parameter int MAX_DATA_BURST = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    input  logic [3:0]        dm_be,
    output logic [31:0]       dm_rdata,
    output logic              dm_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam int              SW      = $clog2(MAX_DATA_BURST + 1);
    localparam logic [SW-1:0]   CNT_MAX = SW'(MAX_DATA_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_INSTR = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]          mem_be_q, mem_be_d;
    logic [SW-1:0]       starve_cnt_q, starve_cnt_d;
    logic                starve_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        starve_cnt_d = starve_cnt_q;
        if_ack       = 1'b0;
        dm_ack       = 1'b0;
        starve_hit   = if_req && (starve_cnt_q == CNT_MAX);

        case (state_q)
            ST_IDLE: begin
                if (dm_req && !starve_hit) begin
                    state_d     = ST_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    // Count only grants that made a pending fetch wait.
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CNT_MAX) begin
                        starve_cnt_d = starve_cnt_q + SW'(1);
                    end
                end else if (if_req) begin
                    state_d      = ST_INSTR;
                    mem_req_d    = 1'b1;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = if_addr;
                    mem_be_d     = 4'b0000;
                    starve_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (mem_ack) begin
                    dm_ack    = 1'b1;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            ST_INSTR: begin
                if (mem_ack) begin
                    if_ack    = 1'b1;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // Read data is only meaningful alongside the matching ack.
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_DATA_BURST, default 4, max consecutive data grants while an instruction fetch waits.
REQ-002 Parameter ADDR_W, default 32, address width; DATA_W fixed at 32.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  fetch request, held with if_addr until if_ack.
REQ-006 if_addr  in  ADDR_W  fetch byte address.
REQ-007 if_rdata  out  32  fetch data, valid when if_ack=1.
REQ-008 if_ack  out  1  one-cycle fetch completion pulse.
REQ-009 dm_req  in  1  data request, held with dm_we/dm_addr/dm_wdata/dm_be until dm_ack.
REQ-010 dm_we  in  1  1=store, 0=load.
REQ-011 dm_addr  in  ADDR_W  data byte address.
REQ-012 dm_wdata  in  32  store data.
REQ-013 dm_be  in  4  store byte enables.
REQ-014 dm_rdata  out  32  load data, valid when dm_ack=1.
REQ-015 dm_ack  out  1  one-cycle data completion pulse.
REQ-016 mem_req  out  1  request to shared memory, registered.
REQ-017 mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/32/4  registered copies of granted request.
REQ-018 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-019 mem_ack  in  1  memory completion, earliest the cycle after mem_req first rises.
REQ-020 busy  out  1  1 when state is not IDLE.

Function
REQ-021 FSM states IDLE, DATA, INSTR; reset state IDLE.
REQ-022 IDLE, dm_req=1, not (if_req=1 and starve_cnt==MAX_DATA_BURST): next state DATA.
REQ-023 IDLE, if_req=1 and (dm_req=0 or starve_cnt==MAX_DATA_BURST): next state INSTR.
REQ-024 IDLE, no requests: stay IDLE, mem_req=0.
REQ-025 On grant edge: latch address, we, wdata, be of granted side into mem_* registers; mem_req=1 from next cycle.
REQ-026 mem_req and mem_* held constant through grant state until mem_ack sampled 1.
REQ-027 INSTR grant forces mem_we=0 and mem_be=4'b0000.
REQ-028 DATA with mem_ack=1: dm_ack=1 and dm_rdata=mem_rdata same cycle (combinational); next state IDLE, mem_req=0 next cycle.
REQ-029 INSTR with mem_ack=1: if_ack=1 and if_rdata=mem_rdata same cycle; next state IDLE, mem_req=0 next cycle.
REQ-030 if_ack/dm_ack never asserted outside INSTR/DATA respectively; never both in one cycle.
REQ-031 Minimum latency req-to-ack 2 cycles (IDLE grant, then ack at earliest); one IDLE bubble between consecutive transactions.
REQ-032 starve_cnt width clog2(MAX_DATA_BURST+1), saturating at MAX_DATA_BURST.
REQ-033 DATA grant with if_req=1: starve_cnt increments; DATA grant with if_req=0: starve_cnt cleared; INSTR grant: starve_cnt cleared.
REQ-034 mem_ack in IDLE ignored, no ack to either side.
REQ-035 Request dropped before grant: ignored, no ack; request dropped after grant: transaction completes, ack still issued.
REQ-036 Inputs sampled only at grant; changes to the granted side's inputs during DATA/INSTR have no effect.
REQ-037 if_rdata/dm_rdata are don't-care when corresponding ack=0.

Reset
REQ-038 rst=0 asynchronously forces IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, starve_cnt=0, busy=0, if_ack=0, dm_ack=0.
REQ-039 Reset mid-transaction abandons it; a late mem_ack after reset release is ignored per REQ-034.
REQ-040 First grant possible on the first rising edge after rst deasserts.

Verification
REQ-041 Fetch only: if_req=1, if_addr=0x10, memory acks 1 cycle after mem_req -> mem_addr=0x10, mem_we=0, if_ack pulse 2 cycles after request, if_rdata=mem_rdata.
REQ-042 Simultaneous: if_req=dm_req=1 in IDLE, starve_cnt=0 -> DATA first (dm_ack), then INSTR (if_ack), starve_cnt back to 0.
REQ-043 Starvation: dm_req held high with new stores after each ack, if_req held, MAX_DATA_BURST=4 -> exactly 4 dm_acks, then if_ack, then data resumes.
REQ-044 Store: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_be=4'b0011, memory ack delayed 3 cycles -> mem_* stable for all 3 wait cycles, one dm_ack, busy=1 throughout.
REQ-045 Reset mid-DATA: rst=0 while waiting for mem_ack -> mem_req=0 immediately; mem_ack after release -> no dm_ack, state IDLE.
REQ-046 Stray mem_ack=1 in IDLE with no requests -> if_ack=dm_ack=0, state unchanged.
